// File: rtl/jtag_link_pkg.sv
// Shared constants and types for the JTAG host link controller.
// Word layouts are fixed by the host protocol, so field positions live here
// rather than being parameters of the controller.
package jtag_link_pkg;

  // Payload width is fixed by the 32-bit word format.
  localparam int PAY_W = 24;

  // Rx command word fields
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;

  // Tx word fields
  localparam int VLD_BIT = 31;
  localparam int SEQ_MSB = 30;
  localparam int SEQ_LSB = 28;
  localparam int CH_MSB  = 27;
  localparam int CH_LSB  = 24;

  // Opcodes
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_FLUSH = 4'h2;
  localparam logic [3:0] OP_MASK  = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [OP_MSB-OP_LSB:0]   op;
    logic [CH_MSB-CH_LSB:0]   ch;
    logic [PAY_W-1:0]         pay;
  } rx_word_t;

  typedef struct packed {
    logic                     vld;
    logic [SEQ_MSB-SEQ_LSB:0] seq;
    logic [CH_MSB-CH_LSB:0]   ch;
    logic [PAY_W-1:0]         pay;
  } tx_word_t;

endpackage

// File: rtl/jtag_link_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr and returns
// the first asserted client as a onehot grant plus its index.
// The pointer is owned by the caller so it only advances on a real grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // One extra bit so ptr+i never overflows before the modulo fold.
  localparam logic [PTR_W:0] N_LIM = (PTR_W+1)'(N_REQ);

  logic [PTR_W:0] cand;

  // Priority scan from ptr, wrapping at N_REQ; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= N_LIM) cand = cand - N_LIM;
      if (!any && req[cand[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = cand[PTR_W-1:0];
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/jtag_link_ctrl.sv
// JTAG host link sequencer: decodes host command words into client strobes
// and round-robins client payloads onto the single tagged send word.
module jtag_link_ctrl #(
  parameter int N_REQ = 4,
  parameter int PAY_W = 24,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            rx_data,
  input  logic                   rx_rdy,
  output logic [31:0]            tx_data,
  input  logic                   tx_taken,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*PAY_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       cmd_valid,
  output logic [PAY_W-1:0]       cmd_data,
  output logic [ERR_W-1:0]       err_count
);
  import jtag_link_pkg::*;

  localparam int             PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0]     CH_LIM = 5'(N_REQ);

  rx_word_t                    rx_w;
  logic [N_REQ-1:0][PAY_W-1:0] req_pay;
  logic [N_REQ-1:0]            mask;
  logic [N_REQ-1:0]            req_elig;
  logic [N_REQ-1:0]            arb_grant;
  logic [PTR_W-1:0]            arb_idx;
  logic                        arb_any;
  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            ptr_nxt;
  logic [2:0]                  seq;
  tx_state_e                   state, state_nxt;
  tx_word_t                    ld_word;
  logic                        op_write, op_flush, op_mask, wr_ok, bad;
  logic                        ld, take, drop;

  assign rx_w     = rx_data;
  assign req_pay  = req_data;
  // Masked clients are simply invisible to the arbiter: no ack, no error.
  assign req_elig = req_valid & mask;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_elig),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Command decode; WRITE to a non-existent channel counts as a bad command.
  always_comb begin
    op_write = rx_rdy && (rx_w.op == OP_WRITE);
    op_flush = rx_rdy && (rx_w.op == OP_FLUSH);
    op_mask  = rx_rdy && (rx_w.op == OP_MASK);
    wr_ok    = op_write && ({1'b0, rx_w.ch} < CH_LIM);
    bad      = rx_rdy && !(wr_ok || op_flush || op_mask);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; tx_taken and FLUSH both leave HOLD (tx_taken takes priority
  // in the output decode below).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req_elig) state_nxt = LOAD;
      LOAD:    state_nxt = arb_any ? HOLD : IDLE;
      HOLD:    if (tx_taken || op_flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: load a word, consume it, or discard it.
  always_comb begin
    ld   = 1'b0;
    take = 1'b0;
    drop = 1'b0;
    case (state)
      LOAD: ld = arb_any;
      HOLD: begin
        take = tx_taken;
        drop = op_flush && !tx_taken;
      end
      default: ;
    endcase
  end

  // Winner's tagged word and the pointer just past it, so a re-requesting
  // client queues behind everyone else.
  always_comb begin
    ld_word.vld = 1'b1;
    ld_word.seq = seq;
    ld_word.ch  = 4'(arb_idx);
    ld_word.pay = req_pay[arb_idx];
    ptr_nxt     = (arb_idx == PTR_W'(N_REQ-1)) ? '0 : arb_idx + PTR_W'(1);
  end

  // Tx word, sequence number, arbitration pointer and ack strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data <= '0;
      seq     <= '0;
      ptr     <= '0;
      req_ack <= '0;
    end else begin
      req_ack <= ld ? arb_grant : '0;
      if (ld) begin
        tx_data <= ld_word;
        ptr     <= ptr_nxt;
      end else if (take) begin
        // Host consumed the word: invalidate it but keep the rest visible.
        tx_data[VLD_BIT] <= 1'b0;
        seq              <= seq + 3'd1;
      end else if (drop) begin
        tx_data <= '0;
      end
    end
  end

  // Command strobes, shared write payload, grant mask and error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask      <= '1;
      cmd_valid <= '0;
      cmd_data  <= '0;
      err_count <= '0;
    end else begin
      cmd_valid <= wr_ok ? (N_REQ'(1) << rx_w.ch) : '0;
      if (wr_ok)   cmd_data <= rx_w.pay;
      if (op_mask) mask     <= rx_w.pay[N_REQ-1:0];
      if (bad && (err_count != '1)) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_jtag_link_ctrl.sv
// Directed bench for jtag_link_ctrl with hand-computed expected words.
module tb_jtag_link_ctrl;

  localparam int N_REQ = 4;
  localparam int PAY_W = 24;
  localparam int ERR_W = 8;

  logic                   clk;
  logic                   reset_n;
  logic [31:0]            rx_data;
  logic                   rx_rdy;
  logic [31:0]            tx_data;
  logic                   tx_taken;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*PAY_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ack;
  logic [N_REQ-1:0]       cmd_valid;
  logic [PAY_W-1:0]       cmd_data;
  logic [ERR_W-1:0]       err_count;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_link_ctrl #(
    .N_REQ (N_REQ),
    .PAY_W (PAY_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .tx_data   (tx_data),
    .tx_taken  (tx_taken),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pay_of(input int i);
    case (i)
      0:       return 24'h111111;
      1:       return 24'h222222;
      2:       return 24'h333333;
      default: return 24'h444444;
    endcase
  endfunction

  function automatic logic [31:0] expw(input logic [2:0] sq, input logic [3:0] ch,
                                       input logic [23:0] pay);
    return {1'b1, sq, ch, pay};
  endfunction

  task automatic send_rx(input logic [31:0] w);
    rx_data = w;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  // Wait (bounded) for an ack, then check the ack vector and the tagged word.
  task automatic wait_ack(input string tag, input logic [3:0] ch, input logic [2:0] sq,
                          input logic [23:0] pay);
    logic [N_REQ-1:0] ea;
    int k;
    ea = 4'b0001 << ch;
    k  = 0;
    while (req_ack == '0 && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_ack"},  32'(req_ack), 32'(ea));
    chk({tag, "_word"}, tx_data, expw(sq, ch, pay));
  endtask

  task automatic serve(input string tag, input logic [3:0] ch, input logic [2:0] sq,
                       input logic [23:0] pay, input bit last);
    wait_ack(tag, ch, sq, pay);
    if (last) req_valid = '0;
    tx_taken = 1'b1;
    tick();
    tx_taken = 1'b0;
    chk({tag, "_vldclr"}, 32'(tx_data[31]), 32'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rx_rdy    = 1'b0;
    tx_taken  = 1'b0;
    reset_n   = 1'b0;
    tick();
    tick();
    reset_n   = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_data   = '0;
    rx_rdy    = 1'b0;
    tx_taken  = 1'b0;
    req_valid = '0;
    req_data  = {pay_of(3), pay_of(2), pay_of(1), pay_of(0)};
    tick();
    tick();

    // Reset state
    chk("rst_tx",   tx_data,             32'd0);
    chk("rst_ack",  32'(req_ack),        32'd0);
    chk("rst_cmdv", 32'(cmd_valid),      32'd0);
    chk("rst_cmdd", 32'(cmd_data),       32'd0);
    chk("rst_err",  32'(err_count),      32'd0);
    reset_n = 1'b1;

    // 1: single client, two-cycle latency, seq advance on take
    req_data[23:0] = 24'hABCDEF;
    req_valid      = 4'b0001;
    tick();
    chk("t1_ack_early", 32'(req_ack), 32'd0);
    tick();
    chk("t1_ack",  32'(req_ack), 32'h1);
    chk("t1_word", tx_data,      32'h80ABCDEF);
    req_valid = '0;
    tick();
    chk("t1_ack_pulse", 32'(req_ack), 32'd0);
    tick();
    tick();
    chk("t1_hold", tx_data, 32'h80ABCDEF);
    tx_taken = 1'b1;
    tick();
    tx_taken = 1'b0;
    chk("t1_taken", tx_data, 32'h00ABCDEF);
    req_valid = 4'b0001;
    serve("t1_seq1", 4'd0, 3'd1, 24'hABCDEF, 1'b1);
    req_data[23:0] = pay_of(0);

    // 2: all four requesting, round-robin order and seq wrap
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++)
      serve($sformatf("t2_w%0d", k), 4'(k % 4), 3'(k), pay_of(k % 4), 1'b0);
    serve("t2_w8", 4'd0, 3'd0, pay_of(0), 1'b1);

    // 3: mask 0101; ptr=1, seq=1 -> 2,0,2,0
    send_rx(32'h30000005);
    req_valid = 4'b1111;
    serve("t3_a", 4'd2, 3'd1, pay_of(2), 1'b0);
    serve("t3_b", 4'd0, 3'd2, pay_of(0), 1'b0);
    serve("t3_c", 4'd2, 3'd3, pay_of(2), 1'b0);
    serve("t3_d", 4'd0, 3'd4, pay_of(0), 1'b1);
    chk("t3_err", 32'(err_count), 32'd0);

    // 4: WRITE decode, bad commands, saturation
    send_rx(32'h1200BEEF);
    chk("t4_cmdv", 32'(cmd_valid), 32'h4);
    chk("t4_cmdd", 32'(cmd_data),  32'h00BEEF);
    tick();
    chk("t4_cmdv_pulse", 32'(cmd_valid), 32'd0);
    send_rx(32'h13000001);
    chk("t4_cmdv_ch3", 32'(cmd_valid), 32'h8);
    chk("t4_cmdd_ch3", 32'(cmd_data),  32'h000001);
    send_rx(32'h17000000);
    chk("t4_badch_cmdv", 32'(cmd_valid), 32'd0);
    chk("t4_badch_cmdd", 32'(cmd_data),  32'h000001);
    send_rx(32'hF0000000);
    chk("t4_err2", 32'(err_count), 32'd2);
    rx_data = 32'hF0000000;
    rx_rdy  = 1'b1;
    repeat (300) tick();
    rx_rdy  = 1'b0;
    chk("t4_err_sat", 32'(err_count), 32'hFF);

    // 5: FLUSH with tx_taken, FLUSH alone, FLUSH in IDLE (seq=5, ptr=1)
    send_rx(32'h3000000F);
    req_valid = 4'b0010;
    wait_ack("t5_a", 4'd1, 3'd5, pay_of(1));
    req_valid = '0;
    rx_data   = 32'h20000000;
    rx_rdy    = 1'b1;
    tx_taken  = 1'b1;
    tick();
    rx_rdy    = 1'b0;
    tx_taken  = 1'b0;
    chk("t5_flush_take", tx_data, 32'h51222222);
    req_valid = 4'b0100;
    wait_ack("t5_b", 4'd2, 3'd6, pay_of(2));
    req_valid = '0;
    send_rx(32'h20000000);
    chk("t5_flush_tx",  tx_data,      32'd0);
    chk("t5_flush_ack", 32'(req_ack), 32'd0);
    req_valid = 4'b1000;
    serve("t5_c", 4'd3, 3'd6, pay_of(3), 1'b1);
    send_rx(32'h20000000);
    chk("t5_flush_idle", tx_data, 32'h63444444);

    // 6: reset in HOLD clears tx_data asynchronously
    req_valid = 4'b0001;
    wait_ack("t6_pre", 4'd0, 3'd7, pay_of(0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_tx",  tx_data,      32'd0);
    chk("t6_async_ack", 32'(req_ack), 32'd0);
    req_valid = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_err",  32'(err_count), 32'd0);
    chk("t6_cmdd", 32'(cmd_data),  32'd0);
    chk("t6_tx",   tx_data,        32'd0);
    req_valid = 4'b1111;
    serve("t6_w0", 4'd0, 3'd0, pay_of(0), 1'b0);
    serve("t6_w1", 4'd1, 3'd1, pay_of(1), 1'b0);
    serve("t6_w2", 4'd2, 3'd2, pay_of(2), 1'b0);
    serve("t6_w3", 4'd3, 3'd3, pay_of(3), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
